// File: rtl/pwm_register_bank_pkg.sv
// PCA9685-style register map constants, per-channel LED configuration record
// and byte-level helpers shared by the register bank and its PWM channels.
package pca9685_pkg;

    localparam logic [7:0] ADDR_MODE1         = 8'h00;
    localparam logic [7:0] ADDR_LED0_ON_L     = 8'h06;
    localparam logic [7:0] ADDR_ALL_LED_ON_L  = 8'hFA;
    localparam logic [7:0] ADDR_ALL_LED_OFF_H = 8'hFD;
    localparam logic [7:0] ADDR_PRE_SCALE     = 8'hFE;

    localparam int MODE1_SLEEP = 4;
    localparam int MODE1_AI    = 5;
    localparam int LED_STRIDE  = 4;

    localparam logic [7:0] MODE1_RST = 8'h11;
    localparam logic [7:0] OFF_H_RST = 8'h10;

    typedef enum logic [1:0] {
        BYTE_ON_L  = 2'd0,
        BYTE_ON_H  = 2'd1,
        BYTE_OFF_L = 2'd2,
        BYTE_OFF_H = 2'd3
    } led_byte_e;

    typedef struct packed {
        logic        full_on;
        logic [11:0] on;
        logic        full_off;
        logic [11:0] off;
    } led_cfg_t;

    localparam led_cfg_t LED_CFG_RST = '{
        full_on:  1'b0,
        on:       12'h000,
        full_off: OFF_H_RST[4],
        off:      {OFF_H_RST[3:0], 8'h00}
    };

    function automatic logic [7:0] led_read_byte(input led_cfg_t c, input led_byte_e s);
        case (s)
            BYTE_ON_L:  return c.on[7:0];
            BYTE_ON_H:  return {3'b000, c.full_on, c.on[11:8]};
            BYTE_OFF_L: return c.off[7:0];
            BYTE_OFF_H: return {3'b000, c.full_off, c.off[11:8]};
            default:    return 8'h00;
        endcase
    endfunction

    // H bytes keep only the 4 value bits and the full-on/full-off flag.
    function automatic led_cfg_t led_write_byte(input led_cfg_t c, input led_byte_e s,
                                                input logic [7:0] d);
        led_cfg_t r;
        r = c;
        case (s)
            BYTE_ON_L:  r.on[7:0] = d;
            BYTE_ON_H:  begin r.on[11:8] = d[3:0]; r.full_on = d[4]; end
            BYTE_OFF_L: r.off[7:0] = d;
            BYTE_OFF_H: begin r.off[11:8] = d[3:0]; r.full_off = d[4]; end
            default:    r = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pwm_register_bank_if.sv
// Byte-strobe link between the I2C target (master) and the register bank (slave).
interface pwm_register_bank_if;
    logic       addr_load_i;
    logic       wr_valid_i;
    logic       rd_req_i;
    logic [7:0] data_i;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;

    modport master (
        output addr_load_i, wr_valid_i, rd_req_i, data_i,
        input  rd_data_o, rd_valid_o
    );

    modport slave (
        input  addr_load_i, wr_valid_i, rd_req_i, data_i,
        output rd_data_o, rd_valid_o
    );
endinterface

// File: rtl/pwm_register_bank_channel.sv
// One PWM channel: active copy of the shadow ON/OFF settings plus the
// phase compare, producing a registered output bit.
module pwm_channel
    import pca9685_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sleep_i,
    input  logic        update_i,
    input  led_cfg_t    shadow_i,
    input  logic [11:0] phase_i,
    output logic        pwm_o
);

    led_cfg_t active;
    logic     level;

    // Full-off beats full-on; ON>OFF is a window that wraps through phase 0.
    always_comb begin
        level = 1'b0;
        if (active.full_off) begin
            level = 1'b0;
        end else if (active.full_on) begin
            level = 1'b1;
        end else if (active.on == active.off) begin
            level = 1'b0;
        end else if (active.on < active.off) begin
            level = (phase_i >= active.on) && (phase_i < active.off);
        end else begin
            level = (phase_i >= active.on) || (phase_i < active.off);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active <= LED_CFG_RST;
            pwm_o  <= 1'b0;
        end else begin
            if (update_i) begin
                active <= shadow_i;
            end
            pwm_o <= level & ~sleep_i;
        end
    end

endmodule

// File: rtl/pwm_register_bank.sv
// PCA9685-style register bank: pointer, register decode and readback,
// prescaler and phase counter driving NUM_CHANNELS double-buffered PWM channels.
module pwm_register_bank
    import pca9685_pkg::*;
#(
    parameter int         NUM_CHANNELS = 16,
    parameter logic [7:0] PRESCALE_RST = 8'h1E
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    pwm_register_bank_if.slave      bus,
    output logic [NUM_CHANNELS-1:0] pwm_o
);

    localparam int LED_END = int'(ADDR_LED0_ON_L) + LED_STRIDE * NUM_CHANNELS;

    logic [7:0]  ptr;
    logic [7:0]  mode1;
    logic [7:0]  prescale;
    logic [7:0]  prescale_cnt;
    logic [11:0] phase;
    led_cfg_t    shadow [NUM_CHANNELS];

    logic        do_load, do_wr, do_rd;
    logic [7:0]  led_off;
    logic [5:0]  led_ch;
    logic        in_led, in_all;
    led_byte_e   led_sel, all_sel, wr_sel;
    logic [7:0]  rd_mux;
    logic        sleep, tick, update;

    assign do_load = bus.addr_load_i;
    assign do_wr   = bus.wr_valid_i & ~bus.addr_load_i;
    assign do_rd   = bus.rd_req_i & ~bus.wr_valid_i & ~bus.addr_load_i;

    assign led_off = ptr - ADDR_LED0_ON_L;
    assign led_ch  = led_off[7:2];
    assign led_sel = led_byte_e'(led_off[1:0]);
    assign all_sel = led_byte_e'(ptr[1:0] + 2'd2);
    assign wr_sel  = in_led ? led_sel : all_sel;
    assign in_led  = (ptr >= ADDR_LED0_ON_L) && (int'(ptr) < LED_END);
    assign in_all  = (ptr >= ADDR_ALL_LED_ON_L) && (ptr <= ADDR_ALL_LED_OFF_H);

    assign sleep  = mode1[MODE1_SLEEP];
    assign tick   = ~sleep && (prescale_cnt == prescale);
    assign update = sleep | (tick & (phase == 12'hFFF));

    // Pointer auto-increment uses the AI bit as it stood before this access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr      <= 8'h00;
            mode1    <= MODE1_RST;
            prescale <= PRESCALE_RST;
        end else begin
            if (do_load) begin
                ptr <= bus.data_i;
            end else if ((do_wr || do_rd) && mode1[MODE1_AI]) begin
                ptr <= ptr + 8'd1;
            end
            if (do_wr && ptr == ADDR_MODE1) begin
                mode1 <= bus.data_i;
            end
            if (do_wr && ptr == ADDR_PRE_SCALE && sleep) begin
                prescale <= bus.data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow[i] <= LED_CFG_RST;
            end
        end else if (do_wr) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if ((in_led && led_ch == 6'(i)) || in_all) begin
                    shadow[i] <= led_write_byte(shadow[i], wr_sel, bus.data_i);
                end
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (ptr == ADDR_MODE1) begin
            rd_mux = mode1;
        end else if (ptr == ADDR_PRE_SCALE) begin
            rd_mux = prescale;
        end else if (in_led) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (led_ch == 6'(i)) begin
                    rd_mux = led_read_byte(shadow[i], led_sel);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.rd_data_o  <= 8'h00;
            bus.rd_valid_o <= 1'b0;
        end else begin
            bus.rd_valid_o <= do_rd;
            if (do_rd) begin
                bus.rd_data_o <= rd_mux;
            end
        end
    end

    // Sleep pins both counters at zero so waking always starts a fresh period.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prescale_cnt <= 8'h00;
            phase        <= 12'h000;
        end else if (sleep) begin
            prescale_cnt <= 8'h00;
            phase        <= 12'h000;
        end else if (tick) begin
            prescale_cnt <= 8'h00;
            phase        <= phase + 12'd1;
        end else begin
            prescale_cnt <= prescale_cnt + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : gen_ch
        pwm_channel u_channel (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .sleep_i  (sleep),
            .update_i (update),
            .shadow_i (shadow[g]),
            .phase_i  (phase),
            .pwm_o    (pwm_o[g])
        );
    end

endmodule
